// File: rtl/mppt_pkg.sv
// ---------------------------------------------------------------------------
// mppt_pkg
// Shared definitions for the randomised perturb-and-observe MPPT tracker and
// the downstream PWM stage: FSM state encoding, datapath widths, default
// duty limits and the PV power helper.
// ---------------------------------------------------------------------------
package mppt_pkg;

    localparam int DUTY_W   = 16;
    localparam int SAMPLE_W = 16;
    localparam int POWER_W  = 32;

    // Default duty limits, also used by the PWM stage to bound its compare value
    localparam logic [DUTY_W-1:0] DUTY_INIT_DEF = 16'd32768;  // 50 %
    localparam logic [DUTY_W-1:0] DUTY_MIN_DEF  = 16'd3277;   // 5 %
    localparam logic [DUTY_W-1:0] DUTY_MAX_DEF  = 16'd62258;  // 95 %

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        DECIDE = 2'd2,
        SETTLE = 2'd3
    } mppt_state_t;

    // Full-precision PV power; 16x16 unsigned always fits in 32 bits
    function automatic logic [POWER_W-1:0] sample_power(
        input logic [SAMPLE_W-1:0] v,
        input logic [SAMPLE_W-1:0] i
    );
        return POWER_W'(v) * POWER_W'(i);
    endfunction

endpackage

// File: rtl/duty_step_clamp.sv
// ---------------------------------------------------------------------------
// duty_step_clamp
// Combinational duty perturbation: applies +/- step to the present duty and
// clamps the result into [i_duty_min, i_duty_max]. Hitting a limit forces the
// direction away from that limit.
//   i_duty        present duty command
//   i_step        perturbation step (17 bits so base + random never wraps)
//   i_dir         resolved direction, 1 = increase
//   i_duty_min    lower clamp
//   i_duty_max    upper clamp
//   o_duty_next   clamped next duty
//   o_dir_force   1 when a limit was hit and direction must be overridden
//   o_dir_forced  direction to use when o_dir_force is set
// ---------------------------------------------------------------------------
module duty_step_clamp
    import mppt_pkg::*;
(
    input  logic [DUTY_W-1:0] i_duty,
    input  logic [DUTY_W:0]   i_step,
    input  logic              i_dir,
    input  logic [DUTY_W-1:0] i_duty_min,
    input  logic [DUTY_W-1:0] i_duty_max,
    output logic [DUTY_W-1:0] o_duty_next,
    output logic              o_dir_force,
    output logic              o_dir_forced
);

    // Signed headroom: 16-bit duty plus 17-bit step can go above 2^17 or below 0
    logic signed [DUTY_W+2:0] w_cand;
    logic signed [DUTY_W+2:0] w_max;
    logic signed [DUTY_W+2:0] w_min;

    // Candidate duty and clamp decision
    always_comb begin
        w_cand       = {(DUTY_W+3){1'b0}};
        w_max        = $signed({3'b000, i_duty_max});
        w_min        = $signed({3'b000, i_duty_min});
        o_duty_next  = i_duty;
        o_dir_force  = 1'b0;
        o_dir_forced = i_dir;
        if (i_dir) begin
            w_cand = $signed({3'b000, i_duty}) + $signed({2'b00, i_step});
        end else begin
            w_cand = $signed({3'b000, i_duty}) - $signed({2'b00, i_step});
        end
        if (w_cand > w_max) begin
            o_duty_next  = i_duty_max;
            o_dir_force  = 1'b1;
            o_dir_forced = 1'b0;
        end else if (w_cand < w_min) begin
            o_duty_next  = i_duty_min;
            o_dir_force  = 1'b1;
            o_dir_forced = 1'b1;
        end else begin
            o_duty_next  = w_cand[DUTY_W-1:0];
        end
    end

endmodule

// File: rtl/rand_perturb_mppt.sv
// ---------------------------------------------------------------------------
// rand_perturb_mppt
// Randomised-step perturb-and-observe MPPT duty tracker. Each accepted PV
// sample produces one duty update of STEP_BASE + (rand_num >> STEP_SHIFT),
// followed by a SETTLE_CYC-cycle settle window during which samples are
// ignored (not queued).
//   clk_P         system clock, rising edge
//   reset         synchronous active-low reset
//   v_sample      PV voltage, unsigned
//   i_sample      PV current, unsigned
//   sample_valid  sample qualifier, only honoured in IDLE
//   rand_num      random word, sampled in DECIDE
//   duty          registered duty command
//   duty_valid    one-cycle pulse on each duty update
//   dir           perturbation direction, 1 = increase
//   busy          high whenever the tracker is not in IDLE
// ---------------------------------------------------------------------------
module rand_perturb_mppt
    import mppt_pkg::*;
#(
    parameter logic [15:0] DUTY_INIT  = 16'd32768,
    parameter logic [15:0] DUTY_MIN   = 16'd3277,
    parameter logic [15:0] DUTY_MAX   = 16'd62258,
    parameter logic [15:0] STEP_BASE  = 16'd64,
    parameter int          STEP_SHIFT = 8,
    parameter int          SETTLE_CYC = 1000
) (
    input  logic        clk_P,
    input  logic        reset,
    input  logic [15:0] v_sample,
    input  logic [15:0] i_sample,
    input  logic        sample_valid,
    input  logic [15:0] rand_num,
    output logic [15:0] duty,
    output logic        duty_valid,
    output logic        dir,
    output logic        busy
);

    localparam int                CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mppt_state_t          r_state;
    mppt_state_t          w_state_nxt;
    logic [SAMPLE_W-1:0]  r_v;
    logic [SAMPLE_W-1:0]  r_i;
    logic [POWER_W-1:0]   r_p_now;
    logic [POWER_W-1:0]   r_p_prev;
    logic                 r_first;
    logic                 r_dir;
    logic [DUTY_W-1:0]    r_duty;
    logic                 r_duty_valid;
    logic                 r_busy;
    logic [CNT_W-1:0]     r_cnt;

    logic [DUTY_W:0]      w_step;
    logic                 w_dir_resolved;
    logic [DUTY_W-1:0]    w_duty_next;
    logic                 w_dir_force;
    logic                 w_dir_forced;
    logic                 w_dir_final;

    assign w_step = {1'b0, STEP_BASE} + {1'b0, (rand_num >> STEP_SHIFT)};

    // Direction before clamping: the first sample after reset has no history
    always_comb begin
        w_dir_resolved = r_dir;
        if (r_first) begin
            w_dir_resolved = 1'b1;
        end else if (r_p_now < r_p_prev) begin
            w_dir_resolved = ~r_dir;
        end else begin
            w_dir_resolved = r_dir;
        end
    end

    duty_step_clamp u_clamp (
        .i_duty       (r_duty),
        .i_step       (w_step),
        .i_dir        (w_dir_resolved),
        .i_duty_min   (DUTY_MIN),
        .i_duty_max   (DUTY_MAX),
        .o_duty_next  (w_duty_next),
        .o_dir_force  (w_dir_force),
        .o_dir_forced (w_dir_forced)
    );

    // A clamp hit overrides the observed direction so the next step moves away
    always_comb begin
        w_dir_final = w_dir_resolved;
        if (w_dir_force) begin
            w_dir_final = w_dir_forced;
        end else begin
            w_dir_final = w_dir_resolved;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (sample_valid) begin
                    w_state_nxt = CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC:   w_state_nxt = DECIDE;
            DECIDE: w_state_nxt = SETTLE;
            SETTLE: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = SETTLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_P) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk_P) begin
        if (!reset) begin
            r_v          <= 16'd0;
            r_i          <= 16'd0;
            r_p_now      <= 32'd0;
            r_p_prev     <= 32'd0;
            r_first      <= 1'b1;
            r_dir        <= 1'b1;
            r_duty       <= DUTY_INIT;
            r_duty_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_cnt        <= {CNT_W{1'b0}};
        end else begin
            r_duty_valid <= 1'b0;
            // busy tracks the state being entered so it rises on the accepting edge
            r_busy       <= (w_state_nxt != IDLE);
            case (r_state)
                IDLE: begin
                    if (sample_valid) begin
                        r_v <= v_sample;
                        r_i <= i_sample;
                    end
                end
                CALC: begin
                    r_p_now <= sample_power(r_v, r_i);
                end
                DECIDE: begin
                    r_duty       <= w_duty_next;
                    r_dir        <= w_dir_final;
                    r_first      <= 1'b0;
                    r_p_prev     <= r_p_now;
                    r_duty_valid <= 1'b1;
                    r_cnt        <= {CNT_W{1'b0}};
                end
                SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= {CNT_W{1'b0}};
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_cnt <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign duty       = r_duty;
    assign duty_valid = r_duty_valid;
    assign dir        = r_dir;
    assign busy       = r_busy;

endmodule

// File: tb/tb_rand_perturb_mppt.sv
// ---------------------------------------------------------------------------
// tb_rand_perturb_mppt
// Two tracker instances share voltage/current/random inputs but have their
// own sample_valid: instance A uses the default 50 % start duty, instance B
// starts at 62200 to exercise the upper clamp. Expected duty/dir come from a
// per-instance arithmetic model of the tracking rules.
// ---------------------------------------------------------------------------
module tb_rand_perturb_mppt;

    localparam int SETTLE = 4;
    localparam int D_MIN  = 3277;
    localparam int D_MAX  = 62258;
    localparam int INIT_A = 32768;
    localparam int INIT_B = 62200;

    logic        clk_P = 1'b0;
    logic        reset;
    logic [15:0] v_sample, i_sample, rand_num;
    logic        sv_a, sv_b;
    logic [15:0] duty_a, duty_b;
    logic        dv_a, dv_b, dir_a, dir_b, busy_a, busy_b;

    always #5 clk_P = ~clk_P;

    rand_perturb_mppt #(.SETTLE_CYC(SETTLE)) dut_a (
        .clk_P(clk_P), .reset(reset), .v_sample(v_sample), .i_sample(i_sample),
        .sample_valid(sv_a), .rand_num(rand_num), .duty(duty_a),
        .duty_valid(dv_a), .dir(dir_a), .busy(busy_a)
    );

    rand_perturb_mppt #(.DUTY_INIT(16'd62200), .SETTLE_CYC(SETTLE)) dut_b (
        .clk_P(clk_P), .reset(reset), .v_sample(v_sample), .i_sample(i_sample),
        .sample_valid(sv_b), .rand_num(rand_num), .duty(duty_b),
        .duty_valid(dv_b), .dir(dir_b), .busy(busy_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, index 0 = A, 1 = B
    int     m_duty  [2];
    bit     m_dir   [2];
    longint m_pprev [2];
    bit     m_first [2];
    int     m_init  [2];

    task automatic m_reset_all();
        for (int w = 0; w < 2; w++) begin
            m_duty[w]  = m_init[w];
            m_dir[w]   = 1'b1;
            m_pprev[w] = 0;
            m_first[w] = 1'b1;
        end
    endtask

    task automatic m_accept(input int w, input logic [15:0] v, input logic [15:0] i,
                            input logic [15:0] r);
        longint p;
        int     step;
        int     cand;
        p    = longint'(v) * longint'(i);
        step = 64 + (int'(r) / 256);
        if (m_first[w]) begin
            m_dir[w]   = 1'b1;
            m_first[w] = 1'b0;
        end else if (p < m_pprev[w]) begin
            m_dir[w] = !m_dir[w];
        end
        cand = m_dir[w] ? (m_duty[w] + step) : (m_duty[w] - step);
        if (cand > D_MAX) begin
            m_duty[w] = D_MAX;
            m_dir[w]  = 1'b0;
        end else if (cand < D_MIN) begin
            m_duty[w] = D_MIN;
            m_dir[w]  = 1'b1;
        end else begin
            m_duty[w] = cand;
        end
        m_pprev[w] = p;
    endtask

    function automatic logic [15:0] obs_duty(input int w);
        return (w == 0) ? duty_a : duty_b;
    endfunction
    function automatic logic obs_dv(input int w);
        return (w == 0) ? dv_a : dv_b;
    endfunction
    function automatic logic obs_dir(input int w);
        return (w == 0) ? dir_a : dir_b;
    endfunction
    function automatic logic obs_busy(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction

    task automatic tick();
        @(posedge clk_P);
        @(negedge clk_P);
    endtask

    // Drives one sample into instance w and records what the outputs did until
    // busy falls. mask bit k re-asserts sample_valid during busy cycle k.
    task automatic run_sample(input int w, input logic [15:0] v, input logic [15:0] i,
                              input logic [15:0] r, input int mask,
                              output int pulses, output int pulse_cyc, output int busy_len,
                              output int duty_chg, output logic [15:0] o_duty,
                              output logic o_dir, output bit timeout);
        logic [15:0] prev;
        v_sample = v;
        i_sample = i;
        rand_num = r;
        if (w == 0) sv_a = 1'b1; else sv_b = 1'b1;
        prev = obs_duty(w);
        tick();
        sv_a = 1'b0;
        sv_b = 1'b0;
        pulses = 0; pulse_cyc = -1; busy_len = 0; duty_chg = 0; timeout = 1'b1;
        o_duty = obs_duty(w);
        o_dir  = obs_dir(w);
        for (int k = 0; k < 40; k++) begin
            if (obs_dv(w)) begin
                pulses++;
                pulse_cyc = k;
                o_duty = obs_duty(w);
                o_dir  = obs_dir(w);
            end
            if (obs_duty(w) !== prev) duty_chg++;
            prev = obs_duty(w);
            if (!obs_busy(w)) begin
                timeout = 1'b0;
                break;
            end
            busy_len++;
            if (k < 32 && mask[k]) begin
                if (w == 0) sv_a = 1'b1; else sv_b = 1'b1;
            end else begin
                sv_a = 1'b0;
                sv_b = 1'b0;
            end
            tick();
        end
        sv_a = 1'b0;
        sv_b = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sv_a = 1'b0; sv_b = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (duty_a !== 16'd32768 || dir_a !== 1'b1 || dv_a !== 1'b0 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a: duty=%0d dir=%b dv=%b busy=%b, want 32768 1 0 0",
                     duty_a, dir_a, dv_a, busy_a);
        end
        n_cmp++;
        if (duty_b !== 16'd62200 || dir_b !== 1'b1 || dv_b !== 1'b0 || busy_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b: duty=%0d dir=%b dv=%b busy=%b, want 62200 1 0 0",
                     duty_b, dir_b, dv_b, busy_b);
        end
        for (int k = 0; k < 5; k++) begin
            v_sample = 16'($urandom);
            i_sample = 16'($urandom);
            rand_num = 16'($urandom);
            tick();
            n_cmp++;
            if (duty_a !== 16'd32768 || dv_a !== 1'b0 || busy_a !== 1'b0) begin
                n_err++;
                $display("FAIL idle_hold: duty=%0d dv=%b busy=%b, want 32768 0 0",
                         duty_a, dv_a, busy_a);
            end
        end
        m_reset_all();
    endtask

    task automatic test_first_sample();
        int pl, pc, bl, dc; logic [15:0] od; logic odir; bit to;
        run_sample(0, 16'd1000, 16'd100, 16'h0000, 0, pl, pc, bl, dc, od, odir, to);
        m_accept(0, 16'd1000, 16'd100, 16'h0000);
        n_cmp++;
        if (od !== 16'd32832 || odir !== 1'b1) begin
            n_err++;
            $display("FAIL first_sample: duty=%0d dir=%b, want 32832 1", od, odir);
        end
        n_cmp++;
        if (to || pl != 1 || pc != 2 || bl != SETTLE + 2 || dc != 1) begin
            n_err++;
            $display("FAIL first_timing: timeout=%0d pulses=%0d at=%0d busy=%0d chg=%0d, want 0 1 2 %0d 1",
                     to, pl, pc, bl, dc, SETTLE + 2);
        end
    endtask

    task automatic test_direction();
        logic [15:0] t_i    [3] = '{16'd120, 16'd110, 16'd110};
        logic [15:0] t_r    [3] = '{16'hFF00, 16'h0000, 16'h0000};
        logic [15:0] t_duty [3] = '{16'd33151, 16'd33087, 16'd33023};
        logic        t_dir  [3] = '{1'b1, 1'b0, 1'b0};
        int pl, pc, bl, dc; logic [15:0] od; logic odir; bit to;
        for (int n = 0; n < 3; n++) begin
            run_sample(0, 16'd1000, t_i[n], t_r[n], 0, pl, pc, bl, dc, od, odir, to);
            m_accept(0, 16'd1000, t_i[n], t_r[n]);
            n_cmp++;
            if (od !== t_duty[n] || odir !== t_dir[n] || to || pl != 1) begin
                n_err++;
                $display("FAIL direction[%0d]: duty=%0d dir=%b pulses=%0d timeout=%0d, want %0d %b 1 0",
                         n, od, odir, pl, to, t_duty[n], t_dir[n]);
            end
        end
    endtask

    task automatic test_clamp();
        logic [15:0] t_duty [2] = '{16'd62258, 16'd62194};
        int pl, pc, bl, dc; logic [15:0] od; logic odir; bit to;
        for (int n = 0; n < 2; n++) begin
            run_sample(1, 16'd500, 16'd200, 16'h0000, 0, pl, pc, bl, dc, od, odir, to);
            m_accept(1, 16'd500, 16'd200, 16'h0000);
            n_cmp++;
            if (od !== t_duty[n] || odir !== 1'b0 || to || pl != 1) begin
                n_err++;
                $display("FAIL clamp[%0d]: duty=%0d dir=%b pulses=%0d timeout=%0d, want %0d 0 1 0",
                         n, od, odir, pl, to, t_duty[n]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int pl, pc, bl, dc; logic [15:0] od; logic odir; bit to;
        logic [15:0] v, i, r;
        v = 16'($urandom); i = 16'($urandom); r = 16'($urandom);
        // bit 0: pulse while in CALC, bit 3: pulse while in SETTLE
        run_sample(0, v, i, r, 32'h9, pl, pc, bl, dc, od, odir, to);
        m_accept(0, v, i, r);
        n_cmp++;
        if (to || pl != 1 || bl != SETTLE + 2 || dc > 1) begin
            n_err++;
            $display("FAIL busy_ignore: timeout=%0d pulses=%0d busy=%0d chg=%0d, want 0 1 %0d <=1",
                     to, pl, bl, dc, SETTLE + 2);
        end
        n_cmp++;
        if (duty_a !== 16'(m_duty[0]) || dir_a !== m_dir[0]) begin
            n_err++;
            $display("FAIL busy_ignore_duty: duty=%0d dir=%b, want %0d %b",
                     duty_a, dir_a, m_duty[0], m_dir[0]);
        end
        // Immediately after IDLE re-entry: must be accepted on the next edge
        v = 16'($urandom); i = 16'($urandom); r = 16'($urandom);
        run_sample(0, v, i, r, 0, pl, pc, bl, dc, od, odir, to);
        m_accept(0, v, i, r);
        n_cmp++;
        if (to || pl != 1 || pc != 2 || bl != SETTLE + 2 || od !== 16'(m_duty[0]) || odir !== m_dir[0]) begin
            n_err++;
            $display("FAIL back_to_back: pulses=%0d at=%0d busy=%0d duty=%0d dir=%b, want 1 2 %0d %0d %b",
                     pl, pc, bl, od, odir, SETTLE + 2, m_duty[0], m_dir[0]);
        end
    endtask

    task automatic test_reset_mid();
        int pl, pc, bl, dc; logic [15:0] od; logic odir; bit to;
        v_sample = 16'd2000; i_sample = 16'd50; rand_num = 16'hFFFF;
        sv_a = 1'b1;
        tick();                 // E0
        sv_a = 1'b0;
        tick();                 // E1, now in DECIDE
        reset = 1'b0;
        tick();                 // DECIDE edge with reset low
        n_cmp++;
        if (duty_a !== 16'd32768 || dv_a !== 1'b0 || busy_a !== 1'b0 || dir_a !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: duty=%0d dv=%b busy=%b dir=%b, want 32768 0 0 1",
                     duty_a, dv_a, busy_a, dir_a);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (dv_a !== 1'b0 || busy_a !== 1'b0 || duty_a !== 16'd32768) begin
            n_err++;
            $display("FAIL reset_mid_after: duty=%0d dv=%b busy=%b, want 32768 0 0",
                     duty_a, dv_a, busy_a);
        end
        m_reset_all();
        run_sample(0, 16'd10, 16'd10, 16'h0000, 0, pl, pc, bl, dc, od, odir, to);
        m_accept(0, 16'd10, 16'd10, 16'h0000);
        n_cmp++;
        if (od !== 16'd32832 || odir !== 1'b1 || pl != 1 || to) begin
            n_err++;
            $display("FAIL reset_mid_first: duty=%0d dir=%b pulses=%0d timeout=%0d, want 32832 1 1 0",
                     od, odir, pl, to);
        end
    endtask

    task automatic test_random();
        int pl, pc, bl, dc, w, exp_chg, old;
        logic [15:0] od; logic odir; bit to;
        logic [15:0] v, i, r;
        v = 16'd0; i = 16'd0;
        for (int n = 0; n < 30; n++) begin
            w = n % 2;
            // Occasionally repeat the operating point to hit the equal-power rule
            if ($urandom_range(0, 3) != 0) begin
                v = 16'($urandom);
                i = 16'($urandom);
            end
            r = 16'($urandom);
            old = m_duty[w];
            run_sample(w, v, i, r, 0, pl, pc, bl, dc, od, odir, to);
            m_accept(w, v, i, r);
            exp_chg = (m_duty[w] != old) ? 1 : 0;
            n_cmp++;
            if (od !== 16'(m_duty[w]) || odir !== m_dir[w]) begin
                n_err++;
                $display("FAIL random[%0d] inst=%0d: duty=%0d dir=%b, want %0d %b",
                         n, w, od, odir, m_duty[w], m_dir[w]);
            end
            n_cmp++;
            if (to || pl != 1 || pc != 2 || bl != SETTLE + 2 || dc != exp_chg) begin
                n_err++;
                $display("FAIL random_timing[%0d]: timeout=%0d pulses=%0d at=%0d busy=%0d chg=%0d, want 0 1 2 %0d %0d",
                         n, to, pl, pc, bl, dc, SETTLE + 2, exp_chg);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_init[0] = INIT_A;
        m_init[1] = INIT_B;
        reset    = 1'b0;
        sv_a     = 1'b0;
        sv_b     = 1'b0;
        v_sample = 16'd0;
        i_sample = 16'd0;
        rand_num = 16'd0;
        @(negedge clk_P);
        test_reset();
        test_first_sample();
        test_direction();
        test_clamp();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
